// File: rtl/fetch_queue.sv
// Instruction fetch queue: a small circular buffer between the iCache and decode.
//
// Parameters:
//   ARCH_BITS        instruction and PC width
//   DEPTH            number of slots, must equal 2**PTR_BITS
//   PTR_BITS         slot index width
//   NOP_INSTRUCTION  instruction word presented while the queue is empty
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, highest priority
//   flush      discards every entry; wins over push and pop
//   in_valid   iCache delivers {in_pc, in_inst} this cycle
//   in_pc      PC of the incoming instruction
//   in_inst    incoming instruction word
//   in_ready   queue not full; depends on registered count only
//   out_valid  head entry valid for decode
//   out_pc     head PC, all ones while empty
//   out_inst   head instruction, NOP_INSTRUCTION while empty
//   out_ready  decode consumes the head this cycle
//   count      number of occupied slots, 0..DEPTH
module fetch_queue #(
   parameter int unsigned ARCH_BITS = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_BITS = 2,
   parameter logic [ARCH_BITS-1:0] NOP_INSTRUCTION = 32'hFFFFFFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [ARCH_BITS-1:0] in_pc,
   input  logic [ARCH_BITS-1:0] in_inst,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [ARCH_BITS-1:0] out_pc,
   output logic [ARCH_BITS-1:0] out_inst,
   input  logic                 out_ready,
   output logic [PTR_BITS:0]    count
);

   localparam logic [PTR_BITS:0] FullCount = (PTR_BITS + 1)'(DEPTH);

   logic [ARCH_BITS-1:0] pc_mem   [DEPTH];
   logic [ARCH_BITS-1:0] inst_mem [DEPTH];

   logic [PTR_BITS-1:0] head_q, head_d;
   logic [PTR_BITS-1:0] tail_q, tail_d;
   logic [PTR_BITS:0]   count_q, count_d;

   logic push;
   logic pop;

   // in_ready looks at the registered count only, so a pop never makes room
   // for a push in the same cycle.
   assign in_ready  = (count_q != FullCount);
   assign out_valid = (count_q != '0);
   assign count     = count_q;

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   // Storage is read only when count is non-zero, so stale slots never leak out.
   assign out_pc   = out_valid ? pc_mem[head_q]   : '1;
   assign out_inst = out_valid ? inst_mem[head_q] : NOP_INSTRUCTION;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            tail_d = tail_q + PTR_BITS'(1);
         end
         if (pop) begin
            head_d = head_q + PTR_BITS'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_BITS + 1)'(1);
            2'b01:   count_d = count_q - (PTR_BITS + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Data storage has no reset; a write during reset is harmless because
   // count is cleared and the slot is never read before being rewritten.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail_q]   <= in_pc;
         inst_mem[tail_q] <= in_inst;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a table of per-cycle vectors plus hand-written
// sequences for steady-state streaming and stall hold.
module tb_fetch_queue;

   localparam logic [31:0] NOP = 32'hFFFFFFFF;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ready;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_queue dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        ordy;
      logic [2:0]  e_count;
      logic        e_in_ready;
      logic        e_out_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'h13570000;
   endfunction

   // Inputs applied for one cycle, followed by the expected state after that edge.
   task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                      input logic ordy, input logic [2:0] ec, input logic erdy,
                      input logic ev, input logic [31:0] epc);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.inst = inst_of(pc); v.ordy = ordy;
      v.e_count = ec; v.e_in_ready = erdy; v.e_out_valid = ev;
      v.e_pc = ev ? epc : NOP;
      v.e_inst = ev ? inst_of(epc) : NOP;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic ordy);
      @(negedge clk);
      rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [2:0] ec, input logic erdy,
                              input logic ev, input logic [31:0] epc, input logic [31:0] einst);
      chk({tag, ".count"}, 32'(count), 32'(ec));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(erdy));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
      chk({tag, ".out_pc"}, out_pc, epc);
      chk({tag, ".out_inst"}, out_inst, einst);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;

      // Reset
      add(1, 0, 0, 32'h0, 0, 3'd0, 1, 0, 32'h0);
      // First push (its inst is overwritten with the literal word below)
      add(0, 0, 1, 32'h1000, 0, 3'd1, 1, 1, 32'h1000);
      add(0, 0, 1, 32'h1004, 0, 3'd2, 1, 1, 32'h1000);
      add(0, 0, 1, 32'h1008, 0, 3'd3, 1, 1, 32'h1000);
      add(0, 0, 1, 32'h100C, 0, 3'd4, 0, 1, 32'h1000);
      // Fifth push while full is ignored
      add(0, 0, 1, 32'h1010, 0, 3'd4, 0, 1, 32'h1000);
      // Drain in order, then empty NOP
      add(0, 0, 0, 32'h0, 1, 3'd3, 1, 1, 32'h1004);
      add(0, 0, 0, 32'h0, 1, 3'd2, 1, 1, 32'h1008);
      add(0, 0, 0, 32'h0, 1, 3'd1, 1, 1, 32'h100C);
      add(0, 0, 0, 32'h0, 1, 3'd0, 1, 0, 32'h0);
      // Fill, then pop and push together while full: push dropped
      add(0, 0, 1, 32'h3000, 0, 3'd1, 1, 1, 32'h3000);
      add(0, 0, 1, 32'h3004, 0, 3'd2, 1, 1, 32'h3000);
      add(0, 0, 1, 32'h3008, 0, 3'd3, 1, 1, 32'h3000);
      add(0, 0, 1, 32'h300C, 0, 3'd4, 0, 1, 32'h3000);
      add(0, 0, 1, 32'h3010, 1, 3'd3, 1, 1, 32'h3004);
      add(0, 0, 0, 32'h0, 1, 3'd2, 1, 1, 32'h3008);
      add(0, 0, 0, 32'h0, 1, 3'd1, 1, 1, 32'h300C);
      add(0, 0, 0, 32'h0, 1, 3'd0, 1, 0, 32'h0);
      // Flush with a concurrent push
      add(0, 0, 1, 32'h4000, 0, 3'd1, 1, 1, 32'h4000);
      add(0, 0, 1, 32'h4004, 0, 3'd2, 1, 1, 32'h4000);
      add(0, 0, 1, 32'h4008, 0, 3'd3, 1, 1, 32'h4000);
      add(0, 1, 1, 32'h2000, 0, 3'd0, 1, 0, 32'h0);
      add(0, 0, 0, 32'h0, 0, 3'd0, 1, 0, 32'h0);
      // After flush the queue restarts from slot 0
      add(0, 0, 1, 32'h5000, 0, 3'd1, 1, 1, 32'h5000);
      add(0, 0, 1, 32'h5004, 0, 3'd2, 1, 1, 32'h5000);
      // Reset beats flush, push and pop
      add(1, 1, 1, 32'h5008, 1, 3'd0, 1, 0, 32'h0);
      add(0, 0, 0, 32'h0, 1, 3'd0, 1, 0, 32'h0);
      vecs[1].inst = 32'h00221800;
      vecs[1].e_inst = 32'h00221800;
      vecs[2].e_inst = 32'h00221800;
      vecs[3].e_inst = 32'h00221800;
      vecs[4].e_inst = 32'h00221800;
      vecs[5].e_inst = 32'h00221800;

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ordy);
         check_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_in_ready,
                     vecs[i].e_out_valid, vecs[i].e_pc, vecs[i].e_inst);
      end

      // Streaming at count=2: simultaneous push/pop across several pointer wraps
      drive(0, 0, 1, 32'h6000, inst_of(32'h6000), 0);
      drive(0, 0, 1, 32'h6004, inst_of(32'h6004), 0);
      check_state("stream_pre", 3'd2, 1, 1, 32'h6000, inst_of(32'h6000));
      for (int i = 0; i < 10; i++) begin
         logic [31:0] pc_in;
         logic [31:0] pc_head;
         pc_in   = 32'h6008 + 32'(4 * i);
         pc_head = 32'h6004 + 32'(4 * i);
         drive(0, 0, 1, pc_in, inst_of(pc_in), 1);
         check_state($sformatf("stream%0d", i), 3'd2, 1, 1, pc_head, inst_of(pc_head));
      end

      // Stall: head held with out_ready low
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 32'h0, 32'h0, 0);
         check_state($sformatf("stall%0d", i), 3'd2, 1, 1, 32'h6028, inst_of(32'h6028));
      end
      drive(0, 0, 0, 32'h0, 32'h0, 1);
      check_state("post_stall0", 3'd1, 1, 1, 32'h602C, inst_of(32'h602C));
      drive(0, 0, 0, 32'h0, 32'h0, 1);
      check_state("post_stall1", 3'd0, 1, 0, NOP, NOP);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ARCH_BITS, default 32, instruction and PC width.
REQ-002 Parameter DEPTH, default 4, number of queue slots; SHALL be 2^PTR_BITS.
REQ-003 Parameter PTR_BITS, default 2, slot index width.
REQ-004 Parameter NOP_INSTRUCTION, default 32'hFFFFFFFF, instruction presented when empty.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 flush  input  1  taken-branch / exception flush; discards all entries.
REQ-008 in_valid  input  1  iCache delivers a valid instruction this cycle.
REQ-009 in_pc  input  ARCH_BITS  PC of the incoming instruction.
REQ-010 in_inst  input  ARCH_BITS  incoming instruction word.
REQ-011 in_ready  output  1  queue can accept; fetch advances pc+4 only when in_valid && in_ready.
REQ-012 out_valid  output  1  head entry is valid for decode.
REQ-013 out_pc  output  ARCH_BITS  PC of the head entry.
REQ-014 out_inst  output  ARCH_BITS  head instruction word.
REQ-015 out_ready  input  1  decode consumes the head this cycle (low during dCache memory stall).
REQ-016 count  output  PTR_BITS+1  number of occupied slots, 0..DEPTH.

Function
REQ-017 Circular buffer: head pointer, tail pointer (PTR_BITS each) and count register; pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 in_ready SHALL equal (count != DEPTH), combinational from registered count only; in_valid and out_ready SHALL NOT affect it.
REQ-019 push = in_valid && in_ready && !flush; on push, write {in_pc,in_inst} at tail, tail <= tail+1.
REQ-020 pop = out_valid && out_ready && !flush; on pop, head <= head+1.
REQ-021 count next = count + push - pop; push and pop in the same cycle SHALL leave count unchanged and move both pointers.
REQ-022 Full (count==DEPTH): in_ready=0, in_valid ignored even if a pop occurs the same cycle (no full-bypass).
REQ-023 Empty (count==0): out_valid=0, out_inst=NOP_INSTRUCTION, out_pc=32'hFFFFFFFF; no write-through: an entry pushed in cycle N is first visible at out_* in cycle N+1.
REQ-024 When count>0: out_valid=1, out_pc/out_inst = stored head entry, combinational from storage.
REQ-025 Order SHALL be strictly FIFO; entries SHALL NOT be reordered or duplicated.
REQ-026 out_* SHALL hold the same head entry while out_ready=0 (stall) for any number of cycles.
REQ-027 flush has priority over push and pop: head<=0, tail<=0, count<=0 next cycle; in_inst presented during the flush cycle is dropped.
REQ-028 Storage contents need no reset; outputs SHALL depend only on count/head so stale data is never presented.

Reset
REQ-029 While rst=1 at posedge: head=0, tail=0, count=0; following cycle out_valid=0, out_inst=32'hFFFFFFFF, out_pc=32'hFFFFFFFF, in_ready=1.
REQ-030 rst SHALL take priority over flush, push and pop; reset mid-operation discards all entries.

Verification
REQ-031 Reset, then in_valid=1, pc=0x1000, inst=0x00221800, out_ready=0 -> next cycle count=1, out_valid=1, out_pc=0x1000, out_inst=0x00221800.
REQ-032 Push 0x1000,0x1004,0x1008,0x100C with out_ready=0 -> count=4, in_ready=0; fifth push 0x1010 ignored; then out_ready=1 for 4 cycles -> outputs 0x1000..0x100C in order, then empty NOP.
REQ-033 count=2, in_valid=1 and out_ready=1 each cycle for 10 cycles -> count stays 2, pointers wrap, PCs emerge in push order with 2-cycle latency.
REQ-034 count=3, flush=1 with in_valid=1 (pc 0x2000) -> next cycle count=0, out_valid=0, out_inst=0xFFFFFFFF; 0x2000 not stored.
REQ-035 Full with out_ready=1 and in_valid=1 same cycle -> count=3, incoming entry dropped, in_ready=1 next cycle.
REQ-036 count=2, rst=1 with flush=1 and in_valid=1 -> count=0, in_ready=1, out_pc=0xFFFFFFFF next cycle.
